// File: rtl/fp_divide96_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_divide96_seq
// Purpose  : Iterative 96-bit floating-point divider (1 sign, 15 exp, 80 frac),
//            restoring division with internal normalize and round.
//            Define FPDIV96_RADIX4_EN for two quotient bits per cycle.
// Revision : 1.0  initial release
// ============================================================================
module fp_divide96_seq #(
    parameter int FPWID   = 96,
    parameter int EXPWID  = 15,
    parameter int FRACWID = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             ld,
    input  logic [FPWID-1:0] a,
    input  logic [FPWID-1:0] b,
    input  logic [2:0]       rm,
    output logic [FPWID-1:0] o,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             invalid,
    output logic             overflow,
    output logic             underflow
);
    localparam int c_MW = FRACWID + 1;
    localparam int c_RW = c_MW + 1;
    localparam int c_QW = c_MW + 3;
`ifdef FPDIV96_RADIX4_EN
    localparam int c_STEPS = 2;
`else
    localparam int c_STEPS = 1;
`endif
    // PREP already retires the first c_STEPS quotient bits, DIV does the rest.
    localparam int          c_ITERS    = (c_QW - c_STEPS) / c_STEPS;
    localparam logic [6:0]  c_CNT_INIT = 7'(c_ITERS - 1);
    localparam logic signed [EXPWID+1:0] c_BIAS  = {3'b000, {(EXPWID-1){1'b1}}};
    localparam logic signed [EXPWID+1:0] c_EMAX  = {2'b00, {EXPWID{1'b1}}};
    localparam logic signed [EXPWID+1:0] c_EZERO = '0;
    localparam logic signed [EXPWID+1:0] c_EONE  = {{(EXPWID+1){1'b0}}, 1'b1};
    localparam logic [EXPWID-1:0] c_EXP_ONES = {EXPWID{1'b1}};
    localparam logic [EXPWID-1:0] c_EXP_MAXF = {{(EXPWID-1){1'b1}}, 1'b0};
    localparam logic [FPWID-1:0]  c_QNAN = {1'b0, c_EXP_ONES, 1'b1, {(FRACWID-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_DIV   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4
    } state_t;

    state_t r_state, w_state_nx;

    logic [FPWID-1:0]         r_a, r_b;
    logic [2:0]               r_rm;
    logic                     r_sign;
    logic signed [EXPWID+1:0] r_exp;
    logic [c_MW-1:0]          r_mb, r_mant;
    logic [c_RW-1:0]          r_rem;
    logic [c_QW-1:0]          r_q;
    logic [6:0]               r_cnt;
    logic                     r_g, r_r, r_s;
    logic                     r_spec, r_spec_inv, r_spec_dbz;
    logic [FPWID-1:0]         r_spec_o;

    // Returns {quotient bit, next partial remainder already shifted left}.
    function automatic logic [c_RW:0] div_step(input logic [c_RW-1:0] rem,
                                               input logic [c_MW-1:0] d);
        logic            qb;
        logic [c_RW-1:0] diff;
        qb   = (rem >= {1'b0, d});
        diff = qb ? (rem - {1'b0, d}) : rem;
        return {qb, diff[c_RW-2:0], 1'b0};
    endfunction

    logic [EXPWID-1:0] w_ea, w_eb;
    logic [c_MW-1:0]   w_ma, w_mb, w_div_d;
    logic              w_sign;
    logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

    assign w_ea     = r_a[FPWID-2:FRACWID];
    assign w_eb     = r_b[FPWID-2:FRACWID];
    assign w_ma     = {1'b1, r_a[FRACWID-1:0]};
    assign w_mb     = {1'b1, r_b[FRACWID-1:0]};
    assign w_sign   = r_a[FPWID-1] ^ r_b[FPWID-1];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == c_EXP_ONES) && (r_a[FRACWID-1:0] == '0);
    assign w_b_inf  = (w_eb == c_EXP_ONES) && (r_b[FRACWID-1:0] == '0);
    assign w_a_nan  = (w_ea == c_EXP_ONES) && (r_a[FRACWID-1:0] != '0);
    assign w_b_nan  = (w_eb == c_EXP_ONES) && (r_b[FRACWID-1:0] != '0);

    logic             w_spec, w_spec_inv, w_spec_dbz;
    logic [FPWID-1:0] w_spec_o;

    always_comb begin
        w_spec     = 1'b1;
        w_spec_inv = 1'b0;
        w_spec_dbz = 1'b0;
        w_spec_o   = '0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_o   = c_QNAN;
            w_spec_inv = 1'b1;
        end else if (w_b_zero && !w_a_inf) begin
            w_spec_o   = {w_sign, c_EXP_ONES, {FRACWID{1'b0}}};
            w_spec_dbz = 1'b1;
        end else if (w_a_inf) begin
            w_spec_o   = {w_sign, c_EXP_ONES, {FRACWID{1'b0}}};
        end else if (w_b_inf || w_a_zero) begin
            w_spec_o   = {w_sign, {(FPWID-1){1'b0}}};
        end else begin
            w_spec     = 1'b0;
        end
    end

    logic [c_RW-1:0]    w_div_rem_in, w_rem_nx;
    logic [c_RW:0]      w_st1;
    logic [c_STEPS-1:0] w_qbits;

    assign w_div_rem_in = (r_state == S_PREP) ? {1'b0, w_ma} : r_rem;
    assign w_div_d      = (r_state == S_PREP) ? w_mb : r_mb;
    assign w_st1        = div_step(w_div_rem_in, w_div_d);
`ifdef FPDIV96_RADIX4_EN
    logic [c_RW:0] w_st2;
    assign w_st2    = div_step(w_st1[c_RW-1:0], w_div_d);
    assign w_qbits  = {w_st1[c_RW], w_st2[c_RW]};
    assign w_rem_nx = w_st2[c_RW-1:0];
`else
    assign w_qbits  = w_st1[c_RW];
    assign w_rem_nx = w_st1[c_RW-1:0];
`endif

    logic                     w_inexact, w_inc, w_ovf_inf;
    logic [c_MW:0]            w_sum;
    logic [FRACWID-1:0]       w_frac_r;
    logic signed [EXPWID+1:0] w_exp_r;
    logic [FPWID-1:0]         w_res_o;
    logic                     w_res_ovf, w_res_unf, w_res_inv, w_res_dbz;

    assign w_inexact = r_g | r_r | r_s;
    always_comb begin
        w_inc     = r_g & (r_r | r_s | r_mant[0]);
        w_ovf_inf = 1'b1;
        case (r_rm)
            3'd1: begin w_inc = 1'b0;                  w_ovf_inf = 1'b0;    end
            3'd2: begin w_inc = r_sign & w_inexact;    w_ovf_inf = r_sign;  end
            3'd3: begin w_inc = ~r_sign & w_inexact;   w_ovf_inf = ~r_sign; end
            3'd4: begin w_inc = r_g;                   w_ovf_inf = 1'b1;    end
            default: ;
        endcase
    end

    // A mantissa carry-out can only produce exactly 2.0, whose fraction is zero.
    assign w_sum    = {1'b0, r_mant} + {{c_MW{1'b0}}, w_inc};
    assign w_frac_r = w_sum[c_MW] ? w_sum[FRACWID:1] : w_sum[FRACWID-1:0];
    assign w_exp_r  = r_exp + {{(EXPWID+1){1'b0}}, w_sum[c_MW]};

    always_comb begin
        w_res_o   = {r_sign, w_exp_r[EXPWID-1:0], w_frac_r};
        w_res_ovf = 1'b0;
        w_res_unf = 1'b0;
        w_res_inv = 1'b0;
        w_res_dbz = 1'b0;
        if (r_spec) begin
            w_res_o   = r_spec_o;
            w_res_inv = r_spec_inv;
            w_res_dbz = r_spec_dbz;
        end else if (w_exp_r >= c_EMAX) begin
            w_res_ovf = 1'b1;
            w_res_o   = w_ovf_inf ? {r_sign, c_EXP_ONES, {FRACWID{1'b0}}}
                                  : {r_sign, c_EXP_MAXF, {FRACWID{1'b1}}};
        end else if (w_exp_r <= c_EZERO) begin
            w_res_unf = 1'b1;
            w_res_o   = {r_sign, {(FPWID-1){1'b0}}};
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (ld) w_state_nx = S_PREP;
            S_PREP:  w_state_nx = w_spec ? S_ROUND : S_DIV;
            S_DIV:   if (r_cnt == '0) w_state_nx = S_NORM;
            S_NORM:  w_state_nx = S_ROUND;
            S_ROUND: w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     r_state <= S_IDLE;
        else if (ce) r_state <= w_state_nx;
    end

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0; r_b <= '0; r_rm <= '0; r_sign <= 1'b0; r_exp <= '0;
            r_mb <= '0; r_mant <= '0; r_rem <= '0; r_q <= '0; r_cnt <= '0;
            r_g <= 1'b0; r_r <= 1'b0; r_s <= 1'b0;
            r_spec <= 1'b0; r_spec_inv <= 1'b0; r_spec_dbz <= 1'b0; r_spec_o <= '0;
            o <= '0; done <= 1'b0; dbz <= 1'b0; invalid <= 1'b0;
            overflow <= 1'b0; underflow <= 1'b0;
        end else if (ce) begin
            done <= (r_state == S_ROUND);
            case (r_state)
                S_IDLE: if (ld) begin
                    r_a  <= a;
                    r_b  <= b;
                    r_rm <= rm;
                end
                S_PREP: begin
                    r_sign     <= w_sign;
                    r_exp      <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + c_BIAS;
                    r_mb       <= w_mb;
                    r_rem      <= w_rem_nx;
                    r_q        <= {r_q[c_QW-1-c_STEPS:0], w_qbits};
                    r_cnt      <= c_CNT_INIT;
                    r_spec     <= w_spec;
                    r_spec_o   <= w_spec_o;
                    r_spec_inv <= w_spec_inv;
                    r_spec_dbz <= w_spec_dbz;
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_q   <= {r_q[c_QW-1-c_STEPS:0], w_qbits};
                    r_cnt <= r_cnt - 7'd1;
                end
                S_NORM: begin
                    if (r_q[c_QW-1]) begin
                        r_mant <= r_q[c_QW-1:3];
                        r_g    <= r_q[2];
                        r_r    <= r_q[1];
                        r_s    <= r_q[0] | (|r_rem);
                    end else begin
                        r_mant <= r_q[c_QW-2:2];
                        r_g    <= r_q[1];
                        r_r    <= r_q[0];
                        r_s    <= |r_rem;
                        r_exp  <= r_exp - c_EONE;
                    end
                end
                S_ROUND: begin
                    o         <= w_res_o;
                    overflow  <= w_res_ovf;
                    underflow <= w_res_unf;
                    invalid   <= w_res_inv;
                    dbz       <= w_res_dbz;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fp_divide96_seq.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for fp_divide96_seq: literal vectors, control corner cases,
// and randomized operands against an arbitrary-precision integer division model.
module tb_fp_divide96_seq;
`ifdef FPDIV96_RADIX4_EN
    localparam int LAT = 45;
`else
    localparam int LAT = 87;
`endif
    localparam logic [95:0] ONE   = 96'h3FFF_0000_0000_0000_0000_0000;
    localparam logic [95:0] THREE = 96'h4000_8000_0000_0000_0000_0000;

    typedef struct packed {
        logic        spec;
        logic        inv;
        logic        dbz;
        logic        ovf;
        logic        unf;
        logic [95:0] o;
    } res_t;

    logic        clk, rst, ce, ld;
    logic [95:0] a, b, o;
    logic [2:0]  rm;
    logic        busy, done, dbz, invalid, overflow, underflow;

    int   errors = 0;
    int   checks = 0;
    int   done_seen = 0;
    res_t expq[$];
    res_t e_r;

    fp_divide96_seq dut (
        .clk(clk), .rst(rst), .ce(ce), .ld(ld), .a(a), .b(b), .rm(rm),
        .o(o), .busy(busy), .done(done), .dbz(dbz), .invalid(invalid),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [99:0] pk(input res_t r);
        return {r.inv, r.dbz, r.ovf, r.unf, r.o};
    endfunction

    // Reference: exact quotient from wide integer division, rounded by the rm rules.
    function automatic res_t model(input logic [95:0] x, input logic [95:0] y, input logic [2:0] m);
        res_t         r;
        logic         s, xz, yz, xi, yi, xn, yn, up, inexact, g, rr, st, to_inf;
        logic [191:0] num, den, q, rem;
        logic [81:0]  mant;
        int           e;
        r  = '0;
        s  = x[95] ^ y[95];
        xz = (x[94:80] == 0);
        yz = (y[94:80] == 0);
        xi = (x[94:80] == 15'h7FFF) && (x[79:0] == 0);
        yi = (y[94:80] == 15'h7FFF) && (y[79:0] == 0);
        xn = (x[94:80] == 15'h7FFF) && (x[79:0] != 0);
        yn = (y[94:80] == 15'h7FFF) && (y[79:0] != 0);
        if (xn || yn || (xz && yz) || (xi && yi)) begin
            r.spec = 1; r.inv = 1; r.o = 96'h7FFF_8000_0000_0000_0000_0000;
        end else if (yz && !xi) begin
            r.spec = 1; r.dbz = 1; r.o = {s, 15'h7FFF, 80'h0};
        end else if (xi) begin
            r.spec = 1; r.o = {s, 15'h7FFF, 80'h0};
        end else if (yi || xz) begin
            r.spec = 1; r.o = {s, 95'h0};
        end else begin
            e   = int'(x[94:80]) - int'(y[94:80]) + 16383;
            num = {111'h0, 1'b1, x[79:0]};
            den = {111'h0, 1'b1, y[79:0]};
            if (num < den) begin e = e - 1; num = num << 84; end
            else num = num << 83;
            q    = num / den;
            rem  = num % den;
            mant = {1'b0, q[83:3]};
            g    = q[2];
            rr   = q[1];
            st   = q[0] | (rem != 0);
            inexact = g | rr | st;
            case (m)
                3'd1: up = 0;
                3'd2: up = s & inexact;
                3'd3: up = !s & inexact;
                3'd4: up = g;
                default: up = g & (rr | st | mant[0]);
            endcase
            mant = mant + {81'h0, up};
            if (mant[81]) begin e = e + 1; mant = mant >> 1; end
            if (e >= 32767) begin
                r.ovf  = 1;
                to_inf = (m == 3'd1) ? 1'b0 : (m == 3'd2) ? s : (m == 3'd3) ? !s : 1'b1;
                r.o    = to_inf ? {s, 15'h7FFF, 80'h0} : {s, 15'h7FFE, {80{1'b1}}};
            end else if (e <= 0) begin
                r.unf = 1; r.o = {s, 95'h0};
            end else begin
                r.o = {s, e[14:0], mant[79:0]};
            end
        end
        return r;
    endfunction

    function automatic logic [95:0] rnd_fp();
        logic [95:0] v;
        int          k;
        v = {$urandom, $urandom, $urandom};
        k = int'($urandom_range(0, 15));
        case (k)
            0: v[94:80] = 15'h0;
            1: begin v[94:80] = 15'h7FFF; v[79:0] = 80'h0; end
            2: v[94:80] = 15'h7FFF;
            3: v[94:80] = 15'($urandom_range(1, 40));
            4: v[94:80] = 15'($urandom_range(32700, 32766));
            5: v[79:0]  = 80'h0;
            6: v[79:0]  = {80{1'b1}};
            default: v[94:80] = 15'($urandom_range(16283, 16483));
        endcase
        return v;
    endfunction

    // Single compare point: every done pulse is matched to the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_seen++;
            if (expq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got o=%h with no operation pending", o);
            end else begin
                e_r = expq.pop_front();
                chk("result", {invalid, dbz, overflow, underflow, o}, pk(e_r));
            end
        end
    end

    // Called just after a rising edge; the current cycle is the ld cycle.
    task automatic run_op(input logic [95:0] x, input logic [95:0] y, input logic [2:0] m,
                          input res_t er, input int lat, input int stall_at, input int xld_at);
        int n, busy_bad;
        busy_bad = 0;
        a = x; b = y; rm = m; ld = 1;
        expq.push_back(er);
        @(posedge clk); #1;
        ld = 0; a = ~x; b = ~y; rm = ~m; n = 1;
        while (!done && n < 400) begin
            if (!busy) busy_bad++;
            ce = !(stall_at > 0 && n >= stall_at && n < stall_at + 5);
            ld = (n == xld_at);
            if (n == xld_at) begin a = ONE; b = THREE; end
            @(posedge clk); #1;
            n++;
        end
        ce = 1; ld = 0;
        chk("latency", n, lat + ((stall_at > 0) ? 5 : 0));
        chk("busy", {busy_bad, busy}, 0);
    endtask

    logic [95:0] va[8], vb[8], vo[8];
    logic [2:0]  vm[8];
    logic [3:0]  vf[8];
    int          vl[8];
    res_t        er, mr;
    logic [95:0] rx, ry;
    logic [2:0]  rmr;
    int          dseen0;

    initial begin
        clk = 0; rst = 1; ce = 1; ld = 0; a = '0; b = '0; rm = '0;
        va[0] = ONE;  vb[0] = ONE;  vm[0] = 0; vo[0] = ONE; vf[0] = 4'b0000; vl[0] = LAT;
        va[1] = 96'h4001_8000_0000_0000_0000_0000; vb[1] = 96'h4000_0000_0000_0000_0000_0000;
        vm[1] = 0; vo[1] = 96'h4000_8000_0000_0000_0000_0000; vf[1] = 4'b0000; vl[1] = LAT;
        va[2] = ONE;  vb[2] = THREE; vm[2] = 0; vo[2] = 96'h3FFD_5555_5555_5555_5555_5555;
        vf[2] = 4'b0000; vl[2] = LAT;
        va[3] = ONE;  vb[3] = THREE; vm[3] = 3; vo[3] = 96'h3FFD_5555_5555_5555_5555_5556;
        vf[3] = 4'b0000; vl[3] = LAT;
        va[4] = ONE;  vb[4] = '0;    vm[4] = 0; vo[4] = 96'h7FFF_0000_0000_0000_0000_0000;
        vf[4] = 4'b0100; vl[4] = 3;
        va[5] = '0;   vb[5] = '0;    vm[5] = 0; vo[5] = 96'h7FFF_8000_0000_0000_0000_0000;
        vf[5] = 4'b1000; vl[5] = 3;
        va[6] = 96'h7FFE_0000_0000_0000_0000_0000; vb[6] = 96'h0001_0000_0000_0000_0000_0000;
        vm[6] = 1; vo[6] = 96'h7FFE_FFFF_FFFF_FFFF_FFFF_FFFF; vf[6] = 4'b0010; vl[6] = LAT;
        va[7] = va[6]; vb[7] = vb[6]; vm[7] = 0; vo[7] = 96'h7FFF_0000_0000_0000_0000_0000;
        vf[7] = 4'b0010; vl[7] = LAT;

        repeat (3) @(posedge clk); #1;
        chk("reset_state", {busy, done, invalid, dbz, overflow, underflow, o}, '0);
        rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            er = '0;
            er.spec = (vl[i] == 3);
            {er.inv, er.dbz, er.ovf, er.unf} = vf[i];
            er.o = vo[i];
            mr = model(va[i], vb[i], vm[i]);
            chk($sformatf("model_vec%0d", i), pk(mr), pk(er));
            run_op(va[i], vb[i], vm[i], er, vl[i], 0, 0);
        end

        // Second ld while busy must be ignored; result still 6/2 = 3.0.
        repeat (2) @(posedge clk); #1;
        er = model(va[1], vb[1], 0);
        chk("ignored_ld_expect", er.o, THREE);
        run_op(va[1], vb[1], 0, er, LAT, 0, 10);

        // Five-cycle ce stall during DIV delays done by exactly five.
        er = model(ONE, THREE, 0);
        run_op(ONE, THREE, 0, er, LAT, 20, 0);

        // Reset at cycle 40 aborts with no done.
        @(posedge clk); #1;
        a = THREE; b = ONE; rm = 0; ld = 1;
        @(posedge clk); #1;
        ld = 0;
        repeat (39) @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("reset_abort", {busy, done, invalid, dbz, overflow, underflow, o}, '0);
        @(posedge clk); #1;
        rst = 0;
        dseen0 = done_seen;
        repeat (120) @(posedge clk);
        #1;
        chk("no_done_after_abort", done_seen - dseen0, 0);

        for (int i = 0; i < 48; i++) begin
            rx  = rnd_fp();
            ry  = rnd_fp();
            rmr = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            er = model(rx, ry, rmr);
            run_op(rx, ry, rmr, er, er.spec ? 3 : LAT, 0, 0);
        end

        repeat (20) @(posedge clk);
        #1;
        chk("queue_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
